// File: rtl/rgb_pwm_gen_pkg.sv
// Shared types and constants for the RGB PWM sequencer: FSM states,
// configuration register addresses and the PWM counter width.
package rgb_pwm_gen_pkg;

  localparam int PWM_BITS = 8;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_WARM,
    ST_RUN,
    ST_COOL
  } state_t;

  localparam logic [2:0] ADDR_PRE_LO = 3'd0;
  localparam logic [2:0] ADDR_PRE_HI = 3'd1;
  localparam logic [2:0] ADDR_DUTY0  = 3'd2;
  localparam logic [2:0] ADDR_DUTY1  = 3'd3;
  localparam logic [2:0] ADDR_DUTY2  = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: the active duty register, a shadow copy that is only
// updated on a period boundary, and a registered comparator output.
module rgb_pwm_chan
  import rgb_pwm_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [PWM_BITS-1:0] i_wdata,
  input  logic                i_load,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_cnt,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_active;
  logic [PWM_BITS-1:0] r_shadow;
  logic [PWM_BITS-1:0] w_active_nxt;
  logic                r_pwm;

  // A write landing on the load cycle must reach the shadow in that cycle.
  assign w_active_nxt = i_we ? i_wdata : r_active;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= '0;
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (i_load) begin
        r_shadow <= w_active_nxt;
      end
      r_pwm <= i_en && (i_cnt < r_shadow);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_gen.sv
// RGB LED PWM sequencer: byte-wide config port, prescaler, shared 8-bit PWM
// counter and an OFF/WARM/RUN/COOL FSM that sequences the bias enable.
module rgb_pwm_gen
  import rgb_pwm_gen_pkg::*;
#(
  parameter int PRE_BITS    = 10,  // expected range 9..16
  parameter int WARM_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [2:0] rgb_pwm,
  output logic       rgbled_en,
  output logic       busy
);

  localparam int                WARM_W    = $clog2(WARM_CYCLES + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM_CYCLES - 1);

  logic [PRE_BITS-1:0] r_prescale;
  logic                r_run;
  logic [PRE_BITS-1:0] r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [WARM_W-1:0]   r_warm_cnt;
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_active;
  logic                w_tick;
  logic                w_wrap;
  logic                w_load;
  logic                w_warm_done;
  logic                w_chan_en;
  logic [2:0]          w_duty_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale <= '0;
      r_run      <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_PRE_LO: r_prescale[7:0]          <= cfg_wdata;
        ADDR_PRE_HI: r_prescale[PRE_BITS-1:8] <= cfg_wdata[PRE_BITS-9:0];
        ADDR_CTRL:   r_run                    <= cfg_wdata[0];
        default:     ;
      endcase
    end
  end

  assign w_duty_we[0] = cfg_we && (cfg_addr == ADDR_DUTY0);
  assign w_duty_we[1] = cfg_we && (cfg_addr == ADDR_DUTY1);
  assign w_duty_we[2] = cfg_we && (cfg_addr == ADDR_DUTY2);

  // Tick only on equality, so a prescale lowered below pre_cnt lets the
  // counter run on to its natural wrap.
  assign w_tick      = (r_state == ST_RUN) && (r_pre_cnt == r_prescale);
  assign w_wrap      = w_tick && (r_pwm_cnt == {PWM_BITS{1'b1}});
  assign w_warm_done = (r_warm_cnt == WARM_LAST);
  assign w_load      = w_wrap || ((r_state == ST_WARM) && (w_state_nxt == ST_RUN));
  assign w_chan_en   = (r_state == ST_RUN) && r_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:  if (r_run) w_state_nxt = ST_WARM;
      ST_WARM: begin
        if (!r_run)           w_state_nxt = ST_COOL;
        else if (w_warm_done) w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (!r_run) w_state_nxt = ST_COOL;
      ST_COOL: begin
        if (r_run)            w_state_nxt = ST_WARM;
        else if (w_warm_done) w_state_nxt = ST_OFF;
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  // The bias enable is registered from the next state so it rises together
  // with the WARM state rather than a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_warm_cnt <= '0;
      r_active   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= (w_state_nxt != ST_OFF);
      if (w_state_nxt != r_state) begin
        r_warm_cnt <= '0;
      end else if ((r_state == ST_WARM) || (r_state == ST_COOL)) begin
        r_warm_cnt <= r_warm_cnt + 1'b1;
      end
    end
  end

  assign rgbled_en = r_active;
  assign busy      = r_active;

  for (genvar g = 0; g < 3; g++) begin : g_chan
    rgb_pwm_chan u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_duty_we[g]),
      .i_wdata (cfg_wdata),
      .i_load  (w_load),
      .i_en    (w_chan_en),
      .i_cnt   (r_pwm_cnt),
      .o_pwm   (rgb_pwm[g])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed self-checking bench for rgb_pwm_gen: warm-up timing, duty ratios,
// prescaled periods, shadow updates, cool-down, re-warm and async reset.
module tb_rgb_pwm_gen;
  import rgb_pwm_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [2:0] rgb_pwm;
  logic       rgbled_en;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cnt_hi[3];

  always #5 clk = ~clk;

  rgb_pwm_gen #(
    .PRE_BITS    (10),
    .WARM_CYCLES (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .rgb_pwm   (rgb_pwm),
    .rgbled_en (rgbled_en),
    .busy      (busy)
  );

  // Returns 1 time unit after the edge that samples the write.
  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // Counts high samples per channel over n clocks.
  task automatic measure(input int n);
    cnt_hi = '{0, 0, 0};
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (rgb_pwm[i]) cnt_hi[i]++;
    end
  endtask

  // Writes run=1 at edge N and returns just after edge N+65, the first RUN cycle.
  task automatic start_run(input string tag);
    cfg_write(ADDR_CTRL, 8'h01);
    @(posedge clk);
    #1;
    checks++;
    if (rgbled_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_en_rise: en=%b busy=%b want 1 1", tag, rgbled_en, busy);
    end
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rgb_pwm !== 3'b000 || rgbled_en !== 1'b1) begin
        failures++;
        $display("FAIL %s_warm cycle %0d: pwm=%b en=%b want 000 1", tag, k, rgb_pwm, rgbled_en);
      end
    end
  endtask

  task automatic stop_run();
    cfg_write(ADDR_CTRL, 8'h00);
    repeat (70) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    #12;
    checks++;
    if (rgb_pwm !== 3'b000 || rgbled_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: pwm=%b en=%b busy=%b want 000 0 0", rgb_pwm, rgbled_en, busy);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rgb_pwm !== 3'b000 || rgbled_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: pwm=%b en=%b busy=%b want 000 0 0", rgb_pwm, rgbled_en, busy);
    end
  endtask

  task automatic test_duty_ratios();
    cfg_write(ADDR_PRE_LO, 8'd0);
    cfg_write(ADDR_PRE_HI, 8'd0);
    cfg_write(ADDR_DUTY0, 8'd64);
    cfg_write(ADDR_DUTY1, 8'd0);
    cfg_write(ADDR_DUTY2, 8'd255);
    start_run("ratio");
    measure(256);
    checks++;
    if (cnt_hi[0] !== 64) begin
      failures++;
      $display("FAIL ratio_ch0: got %0d want 64", cnt_hi[0]);
    end
    checks++;
    if (cnt_hi[1] !== 0) begin
      failures++;
      $display("FAIL ratio_ch1: got %0d want 0", cnt_hi[1]);
    end
    checks++;
    if (cnt_hi[2] !== 255) begin
      failures++;
      $display("FAIL ratio_ch2: got %0d want 255", cnt_hi[2]);
    end
    stop_run();
    checks++;
    if (rgbled_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ratio_stopped: en=%b busy=%b want 0 0", rgbled_en, busy);
    end
  endtask

  task automatic test_prescale();
    cfg_write(ADDR_PRE_LO, 8'd3);
    cfg_write(ADDR_DUTY0, 8'd128);
    start_run("pre3");
    measure(1024);
    checks++;
    if (cnt_hi[0] !== 512) begin
      failures++;
      $display("FAIL pre3_ch0: got %0d want 512", cnt_hi[0]);
    end
    checks++;
    if (cnt_hi[2] !== 1020) begin
      failures++;
      $display("FAIL pre3_ch2: got %0d want 1020", cnt_hi[2]);
    end
    stop_run();
  endtask

  // E = first RUN edge; sample after E+k reflects pwm_cnt = (k-1) mod 256.
  task automatic test_shadow_update();
    cfg_write(ADDR_PRE_LO, 8'd0);
    cfg_write(ADDR_DUTY0, 8'd10);
    start_run("shadow");
    measure(100);
    checks++;
    if (cnt_hi[0] !== 10) begin
      failures++;
      $display("FAIL shadow_p0_head: got %0d want 10", cnt_hi[0]);
    end
    cfg_write(ADDR_DUTY0, 8'd200);  // edge E+101, mid-period
    measure(155);
    checks++;
    if (cnt_hi[0] !== 0) begin
      failures++;
      $display("FAIL shadow_p0_tail: got %0d want 0", cnt_hi[0]);
    end
    measure(256);
    checks++;
    if (cnt_hi[0] !== 200) begin
      failures++;
      $display("FAIL shadow_p1: got %0d want 200", cnt_hi[0]);
    end
    measure(50);
    checks++;
    if (cnt_hi[0] !== 50) begin
      failures++;
      $display("FAIL shadow_p2_head: got %0d want 50", cnt_hi[0]);
    end
    cfg_write(ADDR_DUTY0, 8'd10);   // edge E+563
    measure(204);
    checks++;
    if (cnt_hi[0] !== 149) begin
      failures++;
      $display("FAIL shadow_p2_tail: got %0d want 149", cnt_hi[0]);
    end
    cfg_write(ADDR_DUTY0, 8'd200);  // edge E+768, the wrap edge
    measure(256);
    checks++;
    if (cnt_hi[0] !== 200) begin
      failures++;
      $display("FAIL shadow_wrap_write: got %0d want 200", cnt_hi[0]);
    end
    checks++;
    if (cnt_hi[2] !== 255) begin
      failures++;
      $display("FAIL shadow_ch2: got %0d want 255", cnt_hi[2]);
    end
  endtask

  task automatic test_stop_cool();
    cfg_write(ADDR_CTRL, 8'h00);
    @(posedge clk);
    #1;
    checks++;
    if (rgb_pwm !== 3'b000 || rgbled_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stop_next_edge: pwm=%b en=%b busy=%b want 000 1 1", rgb_pwm, rgbled_en, busy);
    end
    repeat (63) @(posedge clk);
    #1;
    checks++;
    if (rgbled_en !== 1'b1) begin
      failures++;
      $display("FAIL cool_last: en=%b want 1", rgbled_en);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rgbled_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cool_done: en=%b busy=%b want 0 0", rgbled_en, busy);
    end
    start_run("run2");
    cfg_write(ADDR_CTRL, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (rgbled_en !== 1'b1 || rgb_pwm !== 3'b000) begin
      failures++;
      $display("FAIL mid_cool: en=%b pwm=%b want 1 000", rgbled_en, rgb_pwm);
    end
    start_run("rewarm");
    @(posedge clk);
    #1;
    checks++;
    if (rgb_pwm !== 3'b101) begin
      failures++;
      $display("FAIL rewarm_first_pwm: got %b want 101", rgb_pwm);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rgb_pwm !== 3'b000 || rgbled_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: pwm=%b en=%b busy=%b want 000 0 0", rgb_pwm, rgbled_en, busy);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rgb_pwm !== 3'b000 || rgbled_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_off: pwm=%b en=%b busy=%b want 000 0 0", rgb_pwm, rgbled_en, busy);
    end
    // Only duty1 is written; prescale and the other duties must still be 0.
    cfg_write(ADDR_DUTY1, 8'd64);
    cfg_write(3'd6, 8'hFF);
    cfg_write(3'd7, 8'hFF);
    start_run("post_rst");
    measure(256);
    checks++;
    if (cnt_hi[0] !== 0 || cnt_hi[1] !== 64 || cnt_hi[2] !== 0) begin
      failures++;
      $display("FAIL post_reset_regs: got %0d/%0d/%0d want 0/64/0", cnt_hi[0], cnt_hi[1], cnt_hi[2]);
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_duty_ratios();
    test_prescale();
    test_shadow_update();
    test_stop_cool();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
